// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts register-to-register commands, drives an external
// combinational ALU for one cycle, writes the result back into one of four
// general registers and returns the result with flags on a response channel.
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [2:0]   cmd_op_i,
  input  logic [1:0]   cmd_rd_i,
  input  logic [1:0]   cmd_rs1_i,
  input  logic [1:0]   cmd_rs2_i,
  input  logic [N-1:0] cmd_imm_i,
  output logic [2:0]   alu_F_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  input  logic [N-1:0] alu_y_i,
  input  logic         alu_cout_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [N-1:0] rsp_data_o,
  output logic         rsp_cout_o,
  output logic         rsp_zero_o
);

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_ANDN  = 3'd4;
  localparam logic [2:0] OP_ORN   = 3'd5;
  localparam logic [2:0] OP_SLT   = 3'd6;
  localparam logic [2:0] OP_LOADI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Opcode to ALU function code; LOADI bypasses the ALU and keeps F at 000.
  function automatic logic [2:0] op_to_f(input logic [2:0] op);
    logic [2:0] f;
    case (op)
      OP_AND:  f = 3'b000;
      OP_OR:   f = 3'b001;
      OP_ADD:  f = 3'b010;
      OP_SUB:  f = 3'b110;
      OP_ANDN: f = 3'b100;
      OP_ORN:  f = 3'b101;
      OP_SLT:  f = 3'b111;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  // Only the arithmetic operations report the ALU carry.
  function automatic logic op_uses_carry(input logic [2:0] op);
    logic c;
    case (op)
      OP_ADD, OP_SUB, OP_SLT: c = 1'b1;
      default:                c = 1'b0;
    endcase
    return c;
  endfunction

  state_e         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     rd_q, rd_d;
  logic [N-1:0]   imm_q, imm_d;
  logic [2:0]     alu_f_q, alu_f_d;
  logic [N-1:0]   alu_a_q, alu_a_d;
  logic [N-1:0]   alu_b_q, alu_b_d;
  logic [N-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic [N-1:0]   regs_q [4];
  logic           accept_s;
  logic           wr_en_s;
  logic [N-1:0]   result_s;
  logic           cout_s;

  assign accept_s = (state_q == S_IDLE) && cmd_valid_i;
  assign wr_en_s  = (state_q == S_EXEC);

  // Next-state logic: one EXEC cycle per command, RESP held until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) state_d = S_EXEC;
        else             state_d = S_IDLE;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
        else             state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback value and carry selected from the ALU or the immediate.
  always_comb begin
    result_s = alu_y_i;
    cout_s   = 1'b0;
    if (op_q == OP_LOADI) begin
      result_s = imm_q;
      cout_s   = 1'b0;
    end else begin
      result_s = alu_y_i;
      cout_s   = op_uses_carry(op_q) & alu_cout_i;
    end
  end

  // Datapath next values: sample operands at acceptance, capture result in EXEC.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_f_d     = alu_f_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_zero_d  = rsp_zero_q;
    if (accept_s) begin
      op_d  = cmd_op_i;
      rd_d  = cmd_rd_i;
      imm_d = cmd_imm_i;
      if (cmd_op_i == OP_LOADI) begin
        alu_f_d = 3'b000;
        alu_a_d = {N{1'b0}};
        alu_b_d = {N{1'b0}};
      end else begin
        alu_f_d = op_to_f(cmd_op_i);
        alu_a_d = regs_q[cmd_rs1_i];
        alu_b_d = regs_q[cmd_rs2_i];
      end
    end else if (state_q == S_EXEC) begin
      alu_f_d    = 3'b000;
      alu_a_d    = {N{1'b0}};
      alu_b_d    = {N{1'b0}};
      rsp_data_d = result_s;
      rsp_cout_d = cout_s;
      rsp_zero_d = (result_s == {N{1'b0}});
    end else begin
      alu_f_d = alu_f_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      op_q        <= 3'd0;
      rd_q        <= 2'd0;
      imm_q       <= {N{1'b0}};
      alu_f_q     <= 3'b000;
      alu_a_q     <= {N{1'b0}};
      alu_b_q     <= {N{1'b0}};
      rsp_data_q  <= {N{1'b0}};
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_f_q     <= alu_f_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // General register file, written once at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= {N{1'b0}};
    end else if (wr_en_s) begin
      regs_q[rd_q] <= result_s;
    end else begin
      regs_q[rd_q] <= regs_q[rd_q];
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign alu_F_o     = alu_f_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_zero_o  = rsp_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random commands checked
// against an arithmetic reference model of the register file and opcodes.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_rd = 2'd0, cmd_rs1 = 2'd0, cmd_rs2 = 2'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic [2:0] alu_F;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_cout, rsp_zero;

  int total = 0;
  int bad   = 0;
  logic [7:0] regs_m [4];

  always #5 clk = ~clk;

  alu_sequencer #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .cmd_imm_i(cmd_imm),
    .alu_F_o(alu_F), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_y_i(alu_y), .alu_cout_i(alu_cout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_cout_o(rsp_cout), .rsp_zero_o(rsp_zero)
  );

  // Stand-in for the attached combinational ALU.
  logic [7:0] alu_bb;
  logic [8:0] alu_sum;
  always_comb begin
    alu_bb   = alu_F[2] ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_bb} + {8'd0, alu_F[2]};
    alu_cout = alu_sum[8];
    case (alu_F[1:0])
      2'b00:   alu_y = alu_a & alu_bb;
      2'b01:   alu_y = alu_a | alu_bb;
      2'b10:   alu_y = alu_sum[7:0];
      default: alu_y = {7'd0, alu_sum[7]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result, carry and expected ALU function code for one command.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm, output logic [7:0] y, output logic c,
                       output logic [2:0] f);
    int s;
    logic [7:0] d;
    s = int'(a) + int'(b);
    d = a - b;
    case (op)
      3'd0: begin y = a & b;  c = 1'b0;     f = 3'b000; end
      3'd1: begin y = a | b;  c = 1'b0;     f = 3'b001; end
      3'd2: begin y = s[7:0]; c = (s > 255); f = 3'b010; end
      3'd3: begin y = d;      c = (a >= b); f = 3'b110; end
      3'd4: begin y = a & ~b; c = 1'b0;     f = 3'b100; end
      3'd5: begin y = a | ~b; c = 1'b0;     f = 3'b101; end
      3'd6: begin y = {7'd0, d[7]}; c = (a >= b); f = 3'b111; end
      default: begin y = imm; c = 1'b0;     f = 3'b000; end
    endcase
  endtask

  task automatic zero_model();
    for (int i = 0; i < 4; i++) regs_m[i] = 8'd0;
  endtask

  // Drive random ignored traffic on the command port.
  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_rd    = 2'($urandom_range(0, 3));
    cmd_rs1   = 2'($urandom_range(0, 3));
    cmd_rs2   = 2'($urandom_range(0, 3));
    cmd_imm   = 8'($urandom_range(0, 255));
  endtask

  // One full command; called #1 after a rising edge while the DUT is idle.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, input int stall,
                        input bit abort_in_resp);
    logic [7:0] ea, eb, ey;
    logic       ec;
    logic [2:0] ef;
    model(op, regs_m[rs1], regs_m[rs2], imm, ey, ec, ef);
    ea = (op == 3'd7) ? 8'd0 : regs_m[rs1];
    eb = (op == 3'd7) ? 8'd0 : regs_m[rs2];
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    junk_cmd();
    check("exec_ready", cmd_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_alu_F", alu_F, ef);
    check("exec_alu_a", alu_a, ea);
    check("exec_alu_b", alu_b, eb);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    regs_m[rd] = ey;
    check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, ey);
    check("resp_cout", rsp_cout, ec);
    check("resp_zero", rsp_zero, (ey == 8'd0));
    check("resp_alu_F", alu_F, 0);
    check("resp_alu_ab", {alu_a, alu_b}, 0);
    if (abort_in_resp) begin
      cmd_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      zero_model();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_rsp_data", rsp_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      junk_cmd();
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_ready", cmd_ready, 0);
      check("stall_data", {rsp_data, rsp_cout, rsp_zero}, {ey, ec, (ey == 8'd0)});
    end
    junk_cmd();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("done_valid", rsp_valid, 0);
    check("done_ready", cmd_ready, 1);
  endtask

  initial begin
    zero_model();
    #12 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_data, rsp_cout, rsp_zero}, 0);
    check("rst_alu", {alu_F, alu_a, alu_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset registers read as zero.
    do_cmd(3'd2, 2'd0, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    // Load and add.
    do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 8'h02, 0, 1'b0);
    do_cmd(3'd7, 2'd2, 2'd0, 2'd0, 8'h03, 0, 1'b0);
    do_cmd(3'd2, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    check("add_r3", regs_m[3], 8'h05);
    // Subtraction and compare.
    do_cmd(3'd3, 2'd0, 2'd1, 2'd2, 8'h00, 1, 1'b0);
    do_cmd(3'd3, 2'd0, 2'd2, 2'd1, 8'h00, 0, 1'b0);
    do_cmd(3'd6, 2'd0, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    do_cmd(3'd6, 2'd0, 2'd2, 2'd1, 8'h00, 0, 1'b0);
    // Logic operations.
    for (int op = 0; op < 6; op++)
      if (op != 2 && op != 3) do_cmd(3'(op), 2'd0, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    // Overflow with long backpressure.
    do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 8'hFF, 0, 1'b0);
    do_cmd(3'd7, 2'd2, 2'd0, 2'd0, 8'h01, 0, 1'b0);
    do_cmd(3'd2, 2'd0, 2'd1, 2'd2, 8'h00, 5, 1'b0);
    // rd equal to a source reads the old value.
    do_cmd(3'd2, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1'b0);
    do_cmd(3'd1, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1'b0);

    // Random commands.
    for (int n = 0; n < 300; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);
    end

    // Reset during RESP, then reissue.
    do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 8'h5A, 0, 1'b0);
    do_cmd(3'd2, 2'd3, 2'd1, 2'd1, 8'h00, 0, 1'b1);
    @(posedge clk); #1;
    do_cmd(3'd2, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1'b0);
    check("post_rst_r3", regs_m[3], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle command sequencer that drives the team's combinational `Alu` block from the initiator side. It accepts register-to-register commands over a valid/ready handshake and holds four N-bit general registers. Each command presents opcode and operands to the external ALU for one cycle, writes the result back to a register, and returns the result with flags over a valid/ready response channel. It sits between a command source (test harness or a future decoder) and one `Alu` instance.

## Interface
- N, default 8: datapath width; must match the attached ALU.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 ANDN, 5 ORN, 6 SLT, 7 LOADI.
- cmd_rd  input  2  destination register index.
- cmd_rs1  input  2  first source register index (ALU operand a).
- cmd_rs2  input  2  second source register index (ALU operand b).
- cmd_imm  input  N  immediate value, used only by LOADI.
- alu_F  output  3  ALU function code.
- alu_a  output  N  ALU operand a.
- alu_b  output  N  ALU operand b.
- alu_y  input  N  ALU result.
- alu_cout  input  1  ALU carry out.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  N  result written to rd.
- rsp_cout  output  1  carry flag.
- rsp_zero  output  1  1 when rsp_data == 0.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, latch op, rd, imm, regs[rs1] and regs[rs2], then go to EXEC.
- EXEC
  - Drive alu_a and alu_b from the latched operands and alu_F from the opcode mapping below.
  - At the end of the cycle, capture the result and cout, write the result to regs[rd], then go to RESP.
- RESP
  - rsp_valid = 1, with data and flags stable.
  - On rsp_ready, go to IDLE.
- Opcode to alu_F mapping: AND 000, OR 001, ADD 010, SUB 110, ANDN 100, ORN 101, SLT 111.
- LOADI does not use the ALU.
  - Result = imm; rsp_cout = 0.
  - alu_F stays 000 and the operand ports stay 0.
- rsp_cout:
  - ADD, SUB, SLT: alu_cout captured in EXEC.
  - AND, OR, ANDN, ORN, LOADI: 0.
- SUB carry convention: cout = 1 means no borrow (a ≥ b unsigned).
- SLT: the result is alu_y unchanged, so 0 or 1 as produced by the ALU (sign of a−b).
- Outside EXEC, alu_F, alu_a and alu_b are driven to 0.
- Operands are sampled at acceptance. The previous writeback always completes before the next acceptance, so rd == rs1/rs2 across consecutive commands sees the updated value. rd == rs within one command reads the old value.
- While cmd_ready = 0, cmd_valid and all cmd_* inputs are ignored.
- No command is dropped while in IDLE.

## Timing
- Command accepted at rising edge k (cmd_valid & cmd_ready).
- EXEC occupies cycle k..k+1.
- regs[rd] is updated and rsp_valid asserts at edge k+1.
- Response latency is 1 cycle after acceptance.
- With rsp_ready held high, minimum issue interval is 3 cycles: cmd_ready returns to 1 at edge k+2.
- rsp_valid stays asserted and rsp_data, rsp_cout and rsp_zero stay constant until rsp_ready is sampled high.
- rsp_ready asserted during IDLE or EXEC has no effect.
- Reset values, asserted asynchronously:
  - state IDLE, so cmd_ready = 1.
  - rsp_valid = 0; rsp_data = 0; rsp_cout = 0; rsp_zero = 0.
  - alu_F = 0; alu_a = 0; alu_b = 0.
  - All four registers = 0.
- Reset asserted mid-command (EXEC or RESP) discards the command. Its writeback does not occur if reset precedes edge k+1.
- Arithmetic is modulo 2^N. There is no overflow flag.

## Test plan
- Reset, N=8: assert rst_n=0 mid-cycle → all outputs 0 immediately, cmd_ready=1. Then issue ADD r0=r1+r2 → rsp_data=0x00, rsp_zero=1, rsp_cout=0.
- LOADI r1=2, LOADI r2=3, ADD r3=r1+r2 → rsp_data=0x05, rsp_cout=0, rsp_zero=0. alu_F=010 for exactly one cycle. rsp_valid 1 cycle after accept.
- Subtraction:
  - SUB r0=r1−r2 → 0xFF, rsp_cout=0.
  - SUB r0=r2−r1 → 0x01, rsp_cout=1.
  - SLT r0=r1,r2 → 0x01.
  - SLT r0=r2,r1 → 0x00, rsp_zero=1.
- Logic, r1=2, r2=3: AND → 0x02; OR → 0x03; ANDN → 0x00 with rsp_zero=1; ORN → 0xFE. rsp_cout=0 for all four.
- Overflow and backpressure:
  - LOADI r1=0xFF, LOADI r2=0x01, ADD → 0x00, rsp_cout=1, rsp_zero=1.
  - Hold rsp_ready=0 for 5 cycles while toggling cmd_valid with other commands → response stable, cmd_ready=0, no register changes.
- Reset during RESP, then reissue ADD r3=r1+r2 → rsp_valid drops immediately; all registers 0; result 0x00.
